memips_reset_ctrl: RTL and testbench
====================================

# memips_reset_ctrl

Reset controller that receives the raw asynchronous `rst_n` from the board or testbench and distributes staged, synchronously released resets to the MeMIPS memory, pipeline and PC/fetch logic. It also services a one-cycle soft-reset request from the core, which resets the pipeline and PC while memory contents stay intact. The block sits at the top of `MeMIPS`, between the external `clk`/`rst_n` pins and every internal reset consumer.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `rst_n` deassertion; must be >= 2.
- `HOLD_CYCLES`, 4: cycles all domains stay in reset after synchronization; must be >= 1.
- `STAGE_GAP`, 2: cycles between successive domain releases; must be >= 1.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low external reset.
- `soft_rst_req` input 1: one-cycle soft-reset request, synchronous to `clk`.
- `mem_rst_n` output 1: reset for instruction and data memories, active-low.
- `core_rst_n` output 1: reset for pipeline registers and the register file, active-low.
- `pc_rst_n` output 1: reset for PC/fetch, active-low; this domain is released last.
- `rst_busy` output 1: high while any domain is held or being sequenced.
- `rst_cause` output 2: cause of the last reset; `01` = power-on/external, `10` = soft.

## Operation
- Asserting `rst_n` low immediately and asynchronously drives `mem_rst_n`, `core_rst_n` and `pc_rst_n` to 0, `rst_busy` to 1 and `rst_cause` to `01`. The FSM returns to ASSERT.
- The FSM states are ASSERT, HOLD, REL_MEM, REL_CORE, RUN and SOFT_HOLD, with these transitions:
  - ASSERT -> HOLD when the synchronized reset deasserts.
  - HOLD -> REL_MEM after the hold count expires.
  - REL_MEM -> REL_CORE after `STAGE_GAP` cycles.
  - REL_CORE -> RUN after `STAGE_GAP` cycles.
  - RUN -> SOFT_HOLD on `soft_rst_req`.
  - SOFT_HOLD -> REL_CORE after `HOLD_CYCLES` cycles.
- Release order is strictly `mem_rst_n`, then `core_rst_n`, then `pc_rst_n`. At no time may a later domain be released while an earlier one is still in reset.
- Soft reset:
  - `soft_rst_req` is honoured only in RUN.
  - `core_rst_n` and `pc_rst_n` are driven low synchronously. `mem_rst_n` stays at 1.
  - `rst_cause` becomes `10`.
- `soft_rst_req` in any state other than RUN is dropped. It is not queued.
- `rst_cause` is sticky until the next reset event.
- A single counter, sized for `max(HOLD_CYCLES, STAGE_GAP)`, is shared by all timed states and is reloaded on every state entry.
- `rst_n` going low mid-sequence, including during SOFT_HOLD, aborts the sequence and restarts from ASSERT. Power-on cause overrides soft cause.

## Timing
- All outputs are driven directly from flops. No combinational path from `soft_rst_req` to any output.
- External release: number the posedges with `rst_n` high as 1, 2, ….
  - `mem_rst_n` rises after edge `SYNC_STAGES+HOLD_CYCLES` (6 with defaults).
  - `core_rst_n` rises `STAGE_GAP` edges later (8).
  - `pc_rst_n` rises and `rst_busy` falls on the same edge, another `STAGE_GAP` later (10).
- Soft reset: with `soft_rst_req` sampled high at edge k in RUN:
  - `core_rst_n`, `pc_rst_n` go 0 and `rst_busy` goes 1 after edge k.
  - `core_rst_n` rises after edge k+`HOLD_CYCLES`.
  - `pc_rst_n` rises and `rst_busy` falls after edge k+`HOLD_CYCLES`+`STAGE_GAP`.
- Back-to-back `soft_rst_req` on edges k and k+1: the second is ignored, because the FSM is already in SOFT_HOLD.
- A `rst_n` glitch shorter than one cycle still fully resets the block and restarts the full sequence.

## Structure
- Add to the shared `defines.svh` package:
  - state enum `rst_state_t`;
  - cause constants `RST_CAUSE_POR` = `2'b01` and `RST_CAUSE_SOFT` = `2'b10`;
  - default values for `HOLD_CYCLES` and `STAGE_GAP`.
- Sub-module `reset_sync`: a `SYNC_STAGES`-deep flop chain with asynchronous assert and synchronous deassert, producing the internal `sync_rst_n`. It is reusable for future clock domains.
- `memips_reset_ctrl` contains the FSM, counter and output flops only.

## Test plan
- Power-on, defaults: `rst_n` low for 3 cycles, then high mid-cycle -> all outputs 0 and `rst_cause`=`01` while low; `mem_rst_n`=1 after edge 6, `core_rst_n`=1 after edge 8, `pc_rst_n`=1 and `rst_busy`=0 after edge 10.
- Soft reset: after RUN, pulse `soft_rst_req` at edge k -> `mem_rst_n` stays 1; core/pc low after k; `core_rst_n` high after k+4; `pc_rst_n` high after k+6; `rst_cause`=`10`.
- Ignored request: pulse `soft_rst_req` during the external sequence (edge 7) and again at k+1 of a soft reset -> no change to the release edges, no extra reset.
- Mid-sequence abort: drop `rst_n` at edge 7, between the mem and core releases -> `mem_rst_n` goes 0 asynchronously; the sequence restarts and `mem_rst_n` rises 6 edges after the new release; `rst_cause`=`01`.
- Abort during SOFT_HOLD: drop `rst_n` 2 cycles into a soft reset -> all outputs 0 asynchronously; `rst_cause` returns to `01`; the full power-on sequence follows.
- Parameter sweep: `SYNC_STAGES`=3, `HOLD_CYCLES`=1, `STAGE_GAP`=1 -> releases after edges 4, 5 and 6; the ordering invariant holds, checked by a concurrent assertion.

Source files
------------

// File: rtl/memips_reset_ctrl_pkg.sv
// Shared reset-controller types and constants for MeMIPS.
package memips_reset_ctrl_pkg;

  // Sequencer states; domains are released in declaration order.
  typedef enum logic [2:0] {
    StAssert,
    StHold,
    StRelMem,
    StRelCore,
    StRun,
    StSoftHold
  } rst_state_t;

  localparam logic [1:0] RST_CAUSE_POR  = 2'b01;
  localparam logic [1:0] RST_CAUSE_SOFT = 2'b10;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;
  localparam int unsigned STAGE_GAP_DEFAULT   = 2;

  // Bits needed to hold a down-counter loaded with at most max_count-1.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asynchronous assert, synchronous deassert after SYNC_STAGES edges.
module reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift ones in once the raw reset is released; clear the chain instantly on assert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/memips_reset_ctrl.sv
// Staged reset controller: releases memory, then core, then PC/fetch; services soft resets.
module memips_reset_ctrl
  import memips_reset_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int unsigned STAGE_GAP   = STAGE_GAP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  output logic       mem_rst_n,
  output logic       core_rst_n,
  output logic       pc_rst_n,
  output logic       rst_busy,
  output logic [1:0] rst_cause
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CntW   = cnt_width(CntMax);

  // The ASSERT cycle that first sees sync_rst_n high already counts as one hold cycle.
  localparam logic [CntW-1:0] HoldFirstLoad = CntW'(HOLD_CYCLES - 2);
  localparam logic [CntW-1:0] HoldLoad      = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad       = CntW'(STAGE_GAP - 1);

  logic       sync_rst_n;
  rst_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       mem_q, mem_d, core_q, core_d, pc_q, pc_d, busy_q, busy_d;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_rst_n (sync_rst_n)
  );

  // Next state, shared counter reload on entry, and sticky cause.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      StAssert: begin
        if (sync_rst_n) begin
          if (HOLD_CYCLES == 1) begin
            // Single hold cycle is spent in ASSERT itself.
            state_d = StRelMem;
            cnt_d   = GapLoad;
          end else begin
            state_d = StHold;
            cnt_d   = HoldFirstLoad;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StRelMem;
          cnt_d   = GapLoad;
        end
      end
      StRelMem: begin
        if (cnt_q == '0) begin
          state_d = StRelCore;
          cnt_d   = GapLoad;
        end
      end
      StRelCore: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (soft_rst_req) begin
          state_d = StSoftHold;
          cnt_d   = HoldLoad;
          cause_d = RST_CAUSE_SOFT;
        end
      end
      StSoftHold: begin
        if (cnt_q == '0) begin
          state_d = StRelCore;
          cnt_d   = GapLoad;
        end
      end
      default: state_d = StAssert;
    endcase
  end

  // Output levels decoded from the next state so every output comes straight from a flop.
  always_comb begin
    mem_d  = !(state_d inside {StAssert, StHold});
    core_d = state_d inside {StRelCore, StRun};
    pc_d   = (state_d == StRun);
    busy_d = (state_d != StRun);
  end

  // State, counter and output registers; raw rst_n forces everything into reset at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      cause_q <= RST_CAUSE_POR;
      mem_q   <= 1'b0;
      core_q  <= 1'b0;
      pc_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      mem_q   <= mem_d;
      core_q  <= core_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_rst_n  = mem_q;
  assign core_rst_n = core_q;
  assign pc_rst_n   = pc_q;
  assign rst_busy   = busy_q;
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_memips_reset_ctrl.sv
// Directed bench: default-parameter controller plus a SYNC=3/HOLD=1/GAP=1 instance.
module tb_memips_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst_req;
  logic       soft_p;
  logic       mem_rst_n, core_rst_n, pc_rst_n, rst_busy;
  logic [1:0] rst_cause;
  logic       mem_p, core_p, pc_p, busy_p;
  logic [1:0] cause_p;

  int checks   = 0;
  int failures = 0;

  memips_reset_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
    .mem_rst_n    (mem_rst_n),
    .core_rst_n   (core_rst_n),
    .pc_rst_n     (pc_rst_n),
    .rst_busy     (rst_busy),
    .rst_cause    (rst_cause)
  );

  memips_reset_ctrl #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1)
  ) dut_p (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_p),
    .mem_rst_n    (mem_p),
    .core_rst_n   (core_p),
    .pc_rst_n     (pc_p),
    .rst_busy     (busy_p),
    .rst_cause    (cause_p)
  );

  always #5 clk = ~clk;

  // A later domain may never be out of reset while an earlier one is held.
  assert property (@(posedge clk) (!core_rst_n || mem_rst_n) && (!pc_rst_n || core_rst_n))
    else begin
      failures++;
      $error("FAIL order_dflt mem=%b core=%b pc=%b required mem>=core>=pc",
             mem_rst_n, core_rst_n, pc_rst_n);
    end
  assert property (@(posedge clk) (!core_p || mem_p) && (!pc_p || core_p))
    else begin
      failures++;
      $error("FAIL order_sweep mem=%b core=%b pc=%b required mem>=core>=pc",
             mem_p, core_p, pc_p);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
  endtask

  task automatic chk_dflt(input string tag, input logic m, input logic c, input logic p,
                          input logic b, input logic [1:0] cause);
    chk({tag, "_mem"},   {1'b0, mem_rst_n},  {1'b0, m});
    chk({tag, "_core"},  {1'b0, core_rst_n}, {1'b0, c});
    chk({tag, "_pc"},    {1'b0, pc_rst_n},   {1'b0, p});
    chk({tag, "_busy"},  {1'b0, rst_busy},   {1'b0, b});
    chk({tag, "_cause"}, rst_cause,          cause);
  endtask

  task automatic chk_sweep(input string tag, input logic m, input logic c, input logic p,
                           input logic b);
    chk({tag, "_pmem"},   {1'b0, mem_p},  {1'b0, m});
    chk({tag, "_pcore"},  {1'b0, core_p}, {1'b0, c});
    chk({tag, "_ppc"},    {1'b0, pc_p},   {1'b0, p});
    chk({tag, "_pbusy"},  {1'b0, busy_p}, {1'b0, b});
    chk({tag, "_pcause"}, cause_p,        2'b01);
  endtask

  // Optionally release rst_n mid-cycle, then check n edges of the power-on sequence.
  // soft_edge != 0 pulses soft_rst_req so it is sampled on that edge.
  task automatic run_release(input string tag, input bit do_release, input int soft_edge,
                             input int n_edges);
    if (do_release) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    for (int e = 1; e <= n_edges; e++) begin
      soft_rst_req = (e == soft_edge);
      step();
      chk_dflt($sformatf("%s_e%0d", tag, e), e >= 6, e >= 8, e >= 10, e < 10, 2'b01);
      chk_sweep($sformatf("%s_e%0d", tag, e), e >= 4, e >= 5, e >= 6, e < 6);
    end
    soft_rst_req = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    soft_rst_req = 1'b0;
    soft_p       = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_dflt("por_async", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    chk_sweep("por_async", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dflt($sformatf("por_low%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    end

    // Power-on release with an ignored soft request on edge 7.
    run_release("por", 1'b1, 7, 10);

    // Soft reset, with a back-to-back request on k+1 that must be ignored.
    step();
    step();
    soft_rst_req = 1'b1;
    step();
    chk_dflt("soft_k0", 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
    step();
    soft_rst_req = 1'b0;
    chk_dflt("soft_k1", 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
    for (int j = 2; j <= 7; j++) begin
      step();
      chk_dflt($sformatf("soft_k%0d", j), 1'b1, j >= 4, j >= 6, j < 6, 2'b10);
    end
    chk_sweep("soft_other", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_dflt("soft_sticky", 1'b1, 1'b1, 1'b1, 1'b0, 2'b10);

    // External reset from RUN overrides the soft cause.
    rst_n = 1'b0;
    #1;
    chk_dflt("ext_async", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    step();

    // Abort between mem and core release, then full restart.
    run_release("pre_abort", 1'b1, 0, 7);
    rst_n = 1'b0;
    #1;
    chk_dflt("mid_abort", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    chk_sweep("mid_abort", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    run_release("restart", 1'b1, 0, 10);

    // Abort two cycles into a soft reset.
    step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    step();
    step();
    chk_dflt("soft_hold2", 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
    rst_n = 1'b0;
    #1;
    chk_dflt("soft_abort", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    step();
    run_release("soft_restart", 1'b1, 0, 10);

    // Sub-cycle glitch on rst_n still forces a complete restart.
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk_dflt("glitch", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    chk_sweep("glitch", 1'b0, 1'b0, 1'b0, 1'b1);
    run_release("glitch_seq", 1'b0, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
